// File: rtl/regbus_master_pkg.sv
// Shared definitions for the 8-bit register bus initiator.
// Holds the command byte field positions and the controller state encoding.
package regbus_master_pkg;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_INC_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RD     = 3'd3,
    ST_RDWAIT = 3'd4
  } state_e;

endpackage

// File: rtl/regbus_master.sv
// Register bus initiator: converts the host byte stream into single-cycle
// read/write strobes and returns read data as a byte stream.
module regbus_master
  import regbus_master_pkg::*;
#(
  parameter int          ADDR_W       = 6,
  parameter logic [7:0]  TX_IDLE_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic [7:0]        bus_wdata,
  output logic              bus_rd,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                inc_q, inc_d;
  logic                bus_wr_q, bus_wr_d;
  logic                bus_rd_q, bus_rd_d;
  logic [7:0]          bus_wdata_q, bus_wdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                busy_q, busy_d;

  logic                abort;
  logic [ADDR_W-1:0]   cmd_addr;

  // Dropping the link select mid-transaction wins over any byte or ack.
  assign abort    = (state_q != ST_IDLE) && !frame_active;
  assign cmd_addr = rx_data[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_addr_q  <= '0;
      next_addr_q <= '0;
      inc_q       <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wdata_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= TX_IDLE_BYTE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      next_addr_q <= next_addr_d;
      inc_q       <= inc_d;
      bus_wr_q    <= bus_wr_d;
      bus_rd_q    <= bus_rd_d;
      bus_wdata_q <= bus_wdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (frame_active) state_d = ST_CMD;
        ST_CMD:    if (rx_valid) state_d = rx_data[CMD_WR_BIT] ? ST_WDATA : ST_RD;
        ST_WDATA:  state_d = ST_WDATA;
        ST_RD:     state_d = ST_RDWAIT;
        ST_RDWAIT: if (tx_ack && tx_valid_q) state_d = ST_RD;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr_d  = bus_addr_q;
    next_addr_d = next_addr_q;
    inc_d       = inc_q;
    bus_wr_d    = 1'b0;
    bus_rd_d    = 1'b0;
    bus_wdata_d = bus_wdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    if (abort) begin
      tx_valid_d = 1'b0;
      tx_data_d  = TX_IDLE_BYTE;
    end else begin
      unique case (state_q)
        ST_CMD: begin
          if (rx_valid) begin
            inc_d = rx_data[CMD_INC_BIT];
            if (rx_data[CMD_WR_BIT]) begin
              next_addr_d = cmd_addr;
            end else begin
              bus_rd_d    = 1'b1;
              bus_addr_d  = cmd_addr;
              next_addr_d = cmd_addr + ADDR_W'(rx_data[CMD_INC_BIT]);
            end
          end
        end
        ST_WDATA: begin
          if (rx_valid) begin
            bus_wr_d    = 1'b1;
            bus_wdata_d = rx_data;
            bus_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(inc_q);
          end
        end
        ST_RD: begin
          // bus_rd is high this cycle, so bus_rdata reflects the addressed register.
          tx_data_d  = bus_rdata;
          tx_valid_d = 1'b1;
        end
        ST_RDWAIT: begin
          if (tx_ack && tx_valid_q) begin
            tx_valid_d  = 1'b0;
            tx_data_d   = TX_IDLE_BYTE;
            bus_rd_d    = 1'b1;
            bus_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(inc_q);
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wr    = bus_wr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_rd    = bus_rd_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regbus_master.sv
// Self-checking bench for regbus_master: strobe scoreboard plus
// table-driven single writes and hand-written read/abort/reset sequences.
module tb_regbus_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic [5:0] bus_addr;
  logic       bus_wr;
  logic [7:0] bus_wdata;
  logic       bus_rd;
  logic [7:0] bus_rdata;
  logic       busy;

  always #5 clk = ~clk;

  regbus_master #(.ADDR_W(6), .TX_IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ack(tx_ack),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_rdata(bus_rdata), .busy(busy)
  );

  logic [7:0] regs [64];
  assign bus_rdata = regs[bus_addr];

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [5:0] exp_addr;
  } wvec_t;

  strobe_t exp_q[$];
  strobe_t obs [256];
  int      obs_cyc [256];
  int      obs_cnt  = 0;
  int      cyc      = 0;
  int      both_cnt = 0;
  int      rd_idx   = 0;
  int      total    = 0;
  int      bad      = 0;

  // Strobe monitor: records every bus cycle seen on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ((bus_wr || bus_rd) && obs_cnt < 256) begin
      obs[obs_cnt].wr   <= bus_wr;
      obs[obs_cnt].addr <= bus_addr;
      obs[obs_cnt].data <= bus_wdata;
      obs_cyc[obs_cnt]  <= cyc;
      obs_cnt           <= obs_cnt + 1;
    end
    if (bus_wr && bus_rd) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    strobe_t s;
    s.wr = 1'b1; s.addr = a; s.data = d;
    exp_q.push_back(s);
  endtask

  task automatic push_rd(input logic [5:0] a);
    strobe_t s;
    s.wr = 1'b0; s.addr = a; s.data = 8'h00;
    exp_q.push_back(s);
  endtask

  task automatic check_strobes(input string nm);
    strobe_t e, o;
    while (exp_q.size() > 0 && rd_idx < obs_cnt) begin
      e = exp_q.pop_front();
      o = obs[rd_idx];
      rd_idx++;
      chk({nm, " strobe kind"}, o.wr, e.wr);
      chk({nm, " strobe addr"}, o.addr, e.addr);
      if (e.wr) chk({nm, " strobe wdata"}, o.data, e.data);
    end
    chk({nm, " extra strobes"}, obs_cnt - rd_idx, 0);
    chk({nm, " missing strobes"}, exp_q.size(), 0);
    rd_idx = obs_cnt;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    frame_active = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    frame_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic ack_and_check(input string nm, input logic [7:0] exp_byte);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk({nm, " tx_valid drops on ack"}, tx_valid, 0);
    chk({nm, " tx_data idle on ack"}, tx_data, 8'hFF);
    tick();
    chk({nm, " tx_valid 2 edges after ack"}, tx_valid, 1);
    chk({nm, " tx_data"}, tx_data, exp_byte);
  endtask

  wvec_t wv [5];
  int    base;

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'(i * 7 + 3);
    regs[63] = 8'hA5;
    regs[0]  = 8'h5A;
    regs[2]  = 8'h2B;

    wv[0] = '{8'h85, 8'h3C, 6'd5};
    wv[1] = '{8'h80, 8'h00, 6'd0};
    wv[2] = '{8'hBF, 8'hFF, 6'd63};
    wv[3] = '{8'hC0, 8'hE7, 6'd0};
    wv[4] = '{8'h8A, 8'h55, 6'd10};

    rst_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ack = 1'b0;
    #12;
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 8'hFF);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset bus_wr", bus_wr, 0);
    chk("reset bus_rd", bus_rd, 0);
    chk("reset bus_wdata", bus_wdata, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Frame without a command byte: busy but no bus traffic.
    start_frame();
    chk("empty frame busy", busy, 1);
    tick(); tick();
    end_frame();
    chk("empty frame idle", busy, 0);
    check_strobes("empty frame");

    // Single-write frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      start_frame();
      push_wr(wv[i].exp_addr, wv[i].wdata);
      send_byte(wv[i].cmd);
      chk($sformatf("wvec%0d no strobe on cmd", i), bus_wr | bus_rd, 0);
      send_byte(wv[i].wdata);
      chk($sformatf("wvec%0d bus_wr 1 cycle after data", i), bus_wr, 1);
      tick();
      chk($sformatf("wvec%0d bus_wr one cycle", i), bus_wr, 0);
      end_frame();
      check_strobes($sformatf("wvec%0d", i));
    end

    // Back-to-back auto-increment writes.
    start_frame();
    send_byte(8'hC3);
    base = obs_cnt;
    push_wr(6'd3, 8'h11); push_wr(6'd4, 8'h22); push_wr(6'd5, 8'h33);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick(); tick();
    end_frame();
    chk("burst gap 0-1", obs_cyc[base+1] - obs_cyc[base], 1);
    chk("burst gap 1-2", obs_cyc[base+2] - obs_cyc[base+1], 1);
    check_strobes("burst write");

    // Auto-increment read wrapping 63 -> 0.
    start_frame();
    push_rd(6'd63); push_rd(6'd0); push_rd(6'd1);
    send_byte(8'h7F);
    chk("rd63 bus_rd after cmd", bus_rd, 1);
    chk("rd63 tx_valid not yet", tx_valid, 0);
    tick();
    chk("rd63 tx_valid 2 edges after cmd", tx_valid, 1);
    chk("rd63 tx_data", tx_data, 8'hA5);
    ack_and_check("rd0", 8'h5A);
    ack_and_check("rd1", regs[1]);
    end_frame();
    chk("wrap read tx idle", tx_valid, 0);
    check_strobes("wrap read");

    // Non-incrementing read with dummy clock-out bytes.
    start_frame();
    push_rd(6'd2); push_rd(6'd2); push_rd(6'd2); push_rd(6'd2);
    send_byte(8'h02);
    tick();
    chk("rep first tx_data", tx_data, 8'h2B);
    send_byte(8'h85);
    chk("rep dummy ignored tx_valid", tx_valid, 1);
    for (int i = 0; i < 3; i++) ack_and_check($sformatf("rep%0d", i), 8'h2B);
    end_frame();
    check_strobes("repeat read");

    // Stray ack outside a read: ignored.
    start_frame();
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    chk("stray ack tx_valid", tx_valid, 0);
    end_frame();
    check_strobes("stray ack");

    // Frame drop coincident with tx_ack in RDWAIT.
    start_frame();
    push_rd(6'd20);
    send_byte(8'h54);
    tick();
    chk("abort pre tx_valid", tx_valid, 1);
    frame_active = 1'b0;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("abort tx_valid", tx_valid, 0);
    chk("abort tx_data", tx_data, 8'hFF);
    chk("abort busy", busy, 0);
    chk("abort no bus_rd", bus_rd, 0);
    tick(); tick();
    check_strobes("abort");
    start_frame();
    push_wr(6'd1, 8'h99);
    send_byte(8'h81);
    send_byte(8'h99);
    tick();
    end_frame();
    check_strobes("after abort");

    // Asynchronous reset asserted in RDWAIT.
    start_frame();
    push_rd(6'd9);
    send_byte(8'h09);
    tick();
    chk("prereset tx_valid", tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst tx_valid", tx_valid, 0);
    chk("async rst tx_data", tx_data, 8'hFF);
    chk("async rst bus_rd", bus_rd, 0);
    chk("async rst bus_wr", bus_wr, 0);
    chk("async rst busy", busy, 0);
    chk("async rst bus_addr", bus_addr, 0);
    frame_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    check_strobes("async reset");

    chk("rd and wr never together", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
